// File: rtl/fourbyone_pkg.sv
// Shared constants and types for the 4:1 round-robin merging multiplexer.
package fourbyone_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } mux_state_t;

    function automatic logic [NUM_CH-1:0] onehot4(input logic [SEL_W-1:0] idx);
        return NUM_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/fourbyone_rr_mux_arbiter.sv
// Combinational round-robin picker: the search starts at the channel after ptr.
module rr_arbiter4
    import fourbyone_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx
);

    logic [SEL_W-1:0] cand;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        // ptr itself is the last candidate, so the previous winner has lowest priority
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = ptr + SEL_W'(k);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant     = onehot4(cand);
                grant_idx = cand;
            end
        end
    end

endmodule

// File: rtl/fourbyone_rr_mux.sv
// Merges four valid/ready streams onto one registered output; multi-beat
// packets hold the output until their last beat, otherwise round-robin.
module fourbyone_rr_mux
    import fourbyone_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     in_valid,
    input  logic [NUM_CH-1:0]     in_last,
    input  logic [WIDTH-1:0]      in_data0,
    input  logic [WIDTH-1:0]      in_data1,
    input  logic [WIDTH-1:0]      in_data2,
    input  logic [WIDTH-1:0]      in_data3,
    output logic [NUM_CH-1:0]     in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [SEL_W-1:0]      out_sel
);

    mux_state_t        state_q;
    logic [SEL_W-1:0]  rr_ptr_q;
    logic [SEL_W-1:0]  lock_ch_q;
    logic              out_valid_q;
    logic [WIDTH-1:0]  out_data_q;
    logic              out_last_q;
    logic [SEL_W-1:0]  out_sel_q;

    logic [NUM_CH-1:0] arb_grant;
    logic [SEL_W-1:0]  arb_idx;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              load_en;
    logic              xfer;
    logic [WIDTH-1:0]  out_data_d;
    logic              out_last_d;

    rr_arbiter4 u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign load_en = !out_valid_q || out_ready;

    always_comb begin
        grant     = arb_grant;
        grant_idx = arb_idx;
        // a locked channel owns the output even while it idles
        if (state_q == LOCKED) begin
            grant_idx = lock_ch_q;
            grant     = in_valid[lock_ch_q] ? onehot4(lock_ch_q) : '0;
        end
    end

    always_comb begin
        out_data_d = in_data0;
        case (grant_idx)
            2'd0:    out_data_d = in_data0;
            2'd1:    out_data_d = in_data1;
            2'd2:    out_data_d = in_data2;
            default: out_data_d = in_data3;
        endcase
    end

    assign out_last_d = in_last[grant_idx];
    assign xfer       = load_en && (|grant);
    assign in_ready   = (rst_n && load_en) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            rr_ptr_q    <= 2'd3;
            lock_ch_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            if (load_en) begin
                out_valid_q <= xfer;
                if (xfer) begin
                    out_data_q <= out_data_d;
                    out_last_q <= out_last_d;
                    out_sel_q  <= grant_idx;
                end
            end
            if (xfer) begin
                rr_ptr_q <= grant_idx;
                case (state_q)
                    ARB: begin
                        if (!out_last_d) begin
                            lock_ch_q <= grant_idx;
                            state_q   <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (out_last_d) state_q <= ARB;
                    end
                    default: state_q <= ARB;
                endcase
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_fourbyone_rr_mux.sv
// Self-checking bench for fourbyone_rr_mux: vector table, directed corner
// sequences and a randomized run, all cross-checked against a packet-level model.
module tb_fourbyone_rr_mux;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   in_valid = '0;
    logic [3:0]   in_last = '0;
    logic [W-1:0] dv [4];
    logic [3:0]   in_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_last;
    logic [1:0]   out_sel;

    always #5 clk = ~clk;

    fourbyone_rr_mux #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data0  (dv[0]),
        .in_data1  (dv[1]),
        .in_data2  (dv[2]),
        .in_data3  (dv[3]),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: packet owner (-1 = none), previous winner, output beat.
    int         m_lock;
    int         m_last;
    bit         m_ov;
    bit         m_ol;
    logic [7:0] m_od;
    int         m_os;
    logic [3:0] last_rdy;

    task automatic model_reset();
        m_lock = -1;
        m_last = 3;
        m_ov   = 0;
        m_ol   = 0;
        m_od   = '0;
        m_os   = 0;
    endtask

    function automatic int m_grant();
        if (m_lock >= 0) return in_valid[m_lock] ? m_lock : -1;
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_ready();
        int g;
        g = m_grant();
        if ((!m_ov || out_ready) && g >= 0) return 4'(1 << g);
        return 4'b0000;
    endfunction

    task automatic model_clock();
        int g;
        g = m_grant();
        if (!m_ov || out_ready) begin
            if (g >= 0) begin
                m_ov   = 1;
                m_od   = dv[g];
                m_ol   = in_last[g];
                m_os   = g;
                m_last = g;
                if (m_lock < 0) begin
                    if (!in_last[g]) m_lock = g;
                end else if (in_last[g]) begin
                    m_lock = -1;
                end
            end else begin
                m_ov = 0;
            end
        end
    endtask

    // One clock: observe at the falling edge, then advance DUT and model together.
    task automatic cyc(input logic [3:0] er, input logic ev, input logic [7:0] ed,
                       input logic [1:0] es, input logic el, input bit use_exp, input string tag);
        @(negedge clk);
        if (use_exp) begin
            chk({tag, " in_ready"}, 32'(in_ready), 32'(er));
            chk({tag, " out_valid"}, 32'(out_valid), 32'(ev));
            if (ev) begin
                chk({tag, " out_data"}, 32'(out_data), 32'(ed));
                chk({tag, " out_sel"}, 32'(out_sel), 32'(es));
                chk({tag, " out_last"}, 32'(out_last), 32'(el));
            end
        end
        last_rdy = m_ready();
        chk({tag, " model in_ready"}, 32'(in_ready), 32'(last_rdy));
        chk({tag, " model out_valid"}, 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk({tag, " model out_data"}, 32'(out_data), 32'(m_od));
            chk({tag, " model out_sel"}, 32'(out_sel), 32'(m_os));
            chk({tag, " model out_last"}, 32'(out_last), 32'(m_ol));
        end
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic setin(input logic [3:0] v, input logic [3:0] l, input logic [7:0] d0,
                         input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3,
                         input logic r);
        in_valid  = v;
        in_last   = l;
        dv[0]     = d0;
        dv[1]     = d1;
        dv[2]     = d2;
        dv[3]     = d3;
        out_ready = r;
    endtask

    task automatic do_reset();
        in_valid = '0;
        rst_n    = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] v;
        logic [3:0] l;
        logic [7:0] d0, d1, d2, d3;
        logic       ordy;
        logic [3:0] er;
        logic       ev;
        logic [7:0] ed;
        logic [1:0] es;
        logic       el;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1, 4'b0100, 4'b1111, 8'h00, 8'h00, 8'hA5, 8'h00, 1, 4'b0100, 0, 8'h00, 2'd0, 0};
        tbl[1] = '{0, 4'b0000, 4'b1111, 8'h00, 8'h00, 8'hA5, 8'h00, 1, 4'b0000, 1, 8'hA5, 2'd2, 1};
        tbl[2] = '{0, 4'b0000, 4'b1111, 8'h00, 8'h00, 8'hA5, 8'h00, 1, 4'b0000, 0, 8'h00, 2'd0, 0};
        tbl[3] = '{1, 4'b1111, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0001, 0, 8'h00, 2'd0, 0};
        tbl[4] = '{0, 4'b1111, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0010, 1, 8'h10, 2'd0, 1};
        tbl[5] = '{0, 4'b1111, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0100, 1, 8'h11, 2'd1, 1};
        tbl[6] = '{0, 4'b1111, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b1000, 1, 8'h12, 2'd2, 1};
        tbl[7] = '{0, 4'b1111, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0001, 1, 8'h13, 2'd3, 1};
        tbl[8] = '{0, 4'b0000, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0000, 1, 8'h10, 2'd0, 1};
        tbl[9] = '{0, 4'b0000, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0000, 0, 8'h00, 2'd0, 0};

        for (int i = 0; i < 4; i++) dv[i] = '0;
        model_reset();

        // Reset state, with every channel requesting
        setin(4'b1111, 4'b1111, 8'h01, 8'h02, 8'h03, 8'h04, 1);
        #2;
        chk("reset in_ready", 32'(in_ready), 32'h0);
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_data", 32'(out_data), 32'h0);
        chk("reset out_sel", 32'(out_sel), 32'h0);
        chk("reset out_last", 32'(out_last), 32'h0);
        @(posedge clk);
        #1;
        chk("reset held out_valid", 32'(out_valid), 32'h0);

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rst) do_reset();
            setin(tbl[i].v, tbl[i].l, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3, tbl[i].ordy);
            cyc(tbl[i].er, tbl[i].ev, tbl[i].ed, tbl[i].es, tbl[i].el, 1, $sformatf("vec%0d", i));
        end

        // Ch1 three-beat packet against constantly valid ch0/ch3, with a mid-packet idle
        do_reset();
        setin(4'b1011, 4'b1101, 8'h30, 8'h21, 8'h00, 8'h33, 1);
        cyc(4'b0001, 0, 8'h00, 2'd0, 0, 1, "pkt a");
        cyc(4'b0010, 1, 8'h30, 2'd0, 1, 1, "pkt b");
        setin(4'b1011, 4'b1101, 8'h30, 8'h22, 8'h00, 8'h33, 1);
        cyc(4'b0010, 1, 8'h21, 2'd1, 0, 1, "pkt c");
        setin(4'b1001, 4'b1101, 8'h30, 8'h22, 8'h00, 8'h33, 1);
        cyc(4'b0000, 1, 8'h22, 2'd1, 0, 1, "pkt idle");
        setin(4'b1011, 4'b1111, 8'h30, 8'h23, 8'h00, 8'h33, 1);
        cyc(4'b0010, 0, 8'h00, 2'd0, 0, 1, "pkt e");
        setin(4'b1001, 4'b1111, 8'h30, 8'h23, 8'h00, 8'h33, 1);
        cyc(4'b1000, 1, 8'h23, 2'd1, 1, 1, "pkt f");
        cyc(4'b0001, 1, 8'h33, 2'd3, 1, 1, "pkt g");
        setin(4'b0000, 4'b1111, 8'h30, 8'h23, 8'h00, 8'h33, 1);
        cyc(4'b0000, 1, 8'h30, 2'd0, 1, 1, "pkt h");

        // Asynchronous reset in the middle of a ch2 packet
        setin(4'b0100, 4'b1011, 8'h00, 8'h00, 8'h41, 8'h00, 1);
        cyc(4'b0100, 0, 8'h00, 2'd0, 0, 1, "ch2 a");
        setin(4'b0100, 4'b1011, 8'h00, 8'h00, 8'h42, 8'h00, 1);
        cyc(4'b0100, 1, 8'h41, 2'd2, 0, 1, "ch2 b");
        chk("pre-reset out_valid", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'h0);
        chk("async reset in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        setin(4'b0110, 4'b1111, 8'h00, 8'h61, 8'h62, 8'h00, 1);
        cyc(4'b0010, 0, 8'h00, 2'd0, 0, 1, "post-reset a");
        cyc(4'b0100, 1, 8'h61, 2'd1, 1, 1, "post-reset b");
        setin(4'b0000, 4'b1111, 8'h00, 8'h61, 8'h62, 8'h00, 1);
        cyc(4'b0000, 1, 8'h62, 2'd2, 1, 1, "post-reset c");

        // Output stall with a waiting ch0 beat, then drain and reload on one edge
        do_reset();
        setin(4'b0001, 4'b1111, 8'h50, 8'h00, 8'h00, 8'h00, 1);
        cyc(4'b0001, 0, 8'h00, 2'd0, 0, 1, "stall load");
        setin(4'b0001, 4'b1111, 8'h51, 8'h00, 8'h00, 8'h00, 0);
        for (int i = 0; i < 5; i++) cyc(4'b0000, 1, 8'h50, 2'd0, 1, 1, $sformatf("stall%0d", i));
        out_ready = 1'b1;
        cyc(4'b0001, 1, 8'h50, 2'd0, 1, 1, "stall release");
        setin(4'b0000, 4'b1111, 8'h51, 8'h00, 8'h00, 8'h00, 1);
        cyc(4'b0000, 1, 8'h51, 2'd0, 1, 1, "stall reload");

        // Idle stretch must leave the round-robin pointer untouched
        for (int i = 0; i < 10; i++) cyc(4'b0000, 0, 8'h00, 2'd0, 0, 1, $sformatf("idle%0d", i));
        setin(4'b1111, 4'b1111, 8'h70, 8'h71, 8'h72, 8'h73, 1);
        cyc(4'b0010, 0, 8'h00, 2'd0, 0, 1, "idle grant");
        setin(4'b0000, 4'b1111, 8'h70, 8'h71, 8'h72, 8'h73, 1);
        cyc(4'b0000, 1, 8'h71, 2'd1, 1, 1, "idle grant out");

        // Randomized traffic; sources keep a beat stable until it is accepted
        do_reset();
        last_rdy = '0;
        in_valid = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!(in_valid[i] && !last_rdy[i])) begin
                    in_valid[i] = ($urandom_range(0, 2) != 0);
                    in_last[i]  = ($urandom_range(0, 2) == 0);
                    dv[i]       = 8'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cyc(4'b0000, 0, 8'h00, 2'd0, 0, 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
